// File: rtl/timestep_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// timestep_sequencer_pkg
// Definitions shared by the timestep sequencer datapath and the controller
// that consumes INST/T.
//   timestep_t              : 2-bit timestep, T0..T3
//   WORD_W                  : width of the shared data bus / instruction word
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles needed to accept a new button
//                             level (5 ms at 50 MHz)
// -----------------------------------------------------------------------------
package timestep_sequencer_pkg;

    localparam int WORD_W                  = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } timestep_t;

    // Next timestep on an accepted step: a clear wins over the increment.
    function automatic timestep_t next_timestep(input timestep_t cur, input logic clr);
        if (clr) begin
            return T0;
        end
        return timestep_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/timestep_sequencer_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Turns a raw, bouncy, asynchronous active-low push-button into a single
// one-cycle pulse per debounced press.
//   clk    : system clock
//   rst    : asynchronous active-high reset, discards all progress
//   btn_n  : raw active-low button
//   pulse  : one-cycle pulse, the cycle after the debounced level rises
//
// Valid/ready semantics do not apply here: pulse is a fire-and-forget strobe
// that the consumer must act on in the cycle it is high.
//
// Pipeline from a clean press: 2 synchronizer cycles, DEBOUNCE_CYCLES cycles
// of stable difference before the debounced level flips, then 1 cycle for the
// registered rising-edge detect.
// -----------------------------------------------------------------------------
module button_debouncer
    import timestep_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pulse
);

    // A one-cycle debounce would give a zero-width counter; keep at least 1 bit.
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The synchronizer carries the already-inverted level so that its reset
    // value 0 is also the "not pressed" value.
    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_d;
    logic             r_btn_d_q;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    logic             w_btn_s;
    logic             w_differ;
    logic             w_cnt_done;

    assign w_btn_s    = r_sync2;
    assign w_differ   = w_btn_s ^ r_btn_d;
    assign w_cnt_done = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ~btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronized level matches the accepted level
    // restarts the count, so bounces shorter than DEBOUNCE_CYCLES are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_d <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_differ) begin
            r_cnt   <= '0;
        end else if (w_cnt_done) begin
            r_btn_d <= w_btn_s;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Rising edge of the debounced level only; releases produce no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_d_q <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_btn_d_q <= r_btn_d;
            r_pulse   <= r_btn_d & ~r_btn_d_q;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/timestep_sequencer.sv
// -----------------------------------------------------------------------------
// timestep_sequencer
// Single-step front end for a small multicycle processor: each debounced
// press of the Execute button produces one step pulse, which advances the
// timestep counter and optionally captures the bus into the instruction
// register.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   exec_n : raw active-low Execute button (asynchronous, bouncy)
//   bus    : shared data bus, source for the instruction register
//   IRin   : capture bus into INST on the next step
//   Clr    : clear T to T0 on the next step (wins over increment)
//   INST   : registered instruction word
//   T      : registered timestep
//   step   : one-cycle pulse per accepted press
//
// IRin and Clr are qualified by step: outside a step cycle they are ignored.
// INST and T come straight from flops, so the controller sees no
// combinational path from bus/IRin/Clr.
// -----------------------------------------------------------------------------
module timestep_sequencer
    import timestep_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exec_n,
    input  logic [WORD_W-1:0] bus,
    input  logic              IRin,
    input  logic              Clr,
    output logic [WORD_W-1:0] INST,
    output logic [1:0]        T,
    output logic              step
);

    logic              w_step;
    timestep_t         r_t;
    logic [WORD_W-1:0] r_inst;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .rst   (rst),
        .btn_n (exec_n),
        .pulse (w_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t <= T0;
        end else if (w_step) begin
            r_t <= next_timestep(r_t, Clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= '0;
        end else if (w_step && IRin) begin
            r_inst <= bus;
        end
    end

    assign INST = r_inst;
    assign T    = r_t;
    assign step = w_step;

endmodule

// File: tb/tb_timestep_sequencer.sv
module tb_timestep_sequencer;
    import timestep_sequencer_pkg::*;

    localparam int DC = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       exec_n;
    logic [9:0] bus;
    logic       IRin;
    logic       Clr;
    logic [9:0] INST;
    logic [1:0] T;
    logic       step;

    always #5 clk = ~clk;

    timestep_sequencer #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .exec_n (exec_n),
        .bus    (bus),
        .IRin   (IRin),
        .Clr    (Clr),
        .INST   (INST),
        .T      (T),
        .step   (step)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_q[$];   // {T, INST} expected after each step

    typedef struct {
        logic       clr;
        logic       irin;
        logic [9:0] bus;
        logic [1:0] exp_t;
        logic [9:0] exp_inst;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n, output int steps);
        steps = 0;
        repeat (n) begin
            @(negedge clk);
            if (step === 1'b1) steps++;
        end
    endtask

    task automatic wait_step(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (step === 1'b1) seen = 1'b1;
        end
    endtask

    // One full press/release with Clr/IRin/bus held for the whole press.
    // hold_t/hold_inst are the values that must still be present in the step
    // cycle itself (Clr/IRin without step must do nothing).
    task automatic press(input string tag, input logic clr, input logic irin,
                         input logic [9:0] b, input logic [1:0] hold_t,
                         input logic [9:0] hold_inst, input int hold_cycles);
        int          cyc;
        int          extra;
        bit          seen;
        logic [11:0] e;
        Clr    = clr;
        IRin   = irin;
        bus    = b;
        exec_n = 1'b0;
        wait_step(15, cyc, seen);
        check($sformatf("%s step_seen", tag), {31'd0, seen}, 32'd1);
        if (seen) begin
            check($sformatf("%s latency_in_6_8", tag), {31'd0, (cyc >= 6 && cyc <= 8)}, 32'd1);
            check($sformatf("%s T_hold", tag), {30'd0, T}, {30'd0, hold_t});
            check($sformatf("%s INST_hold", tag), {22'd0, INST}, {22'd0, hold_inst});
            @(negedge clk);
            check($sformatf("%s step_one_cycle", tag), {31'd0, step}, 32'd0);
            if (exp_q.size() == 0) begin
                check($sformatf("%s queue_nonempty", tag), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s T", tag), {30'd0, T}, {30'd0, e[11:10]});
                check($sformatf("%s INST", tag), {22'd0, INST}, {22'd0, e[9:0]});
            end
        end
        Clr  = 1'b0;
        IRin = 1'b0;
        bus  = 10'($urandom_range(0, 1023));
        idle(hold_cycles, extra);
        check($sformatf("%s no_repeat_while_held", tag), extra, 0);
        exec_n = 1'b1;
        idle(12, extra);
        check($sformatf("%s no_step_on_release", tag), extra, 0);
    endtask

    // ---------------- test ----------------
    initial begin
        int          n;
        int          cyc;
        bit          seen;

        vecs[0]  = '{clr: 1'b0, irin: 1'b1, bus: 10'h245, exp_t: 2'd2, exp_inst: 10'h245};
        vecs[1]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h0AA, exp_t: 2'd3, exp_inst: 10'h245};
        vecs[2]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h155, exp_t: 2'd0, exp_inst: 10'h245};
        vecs[3]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h3FF, exp_t: 2'd1, exp_inst: 10'h245};
        vecs[4]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h001, exp_t: 2'd2, exp_inst: 10'h245};
        vecs[5]  = '{clr: 1'b1, irin: 1'b1, bus: 10'h3FF, exp_t: 2'd0, exp_inst: 10'h3FF};
        vecs[6]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h123, exp_t: 2'd1, exp_inst: 10'h3FF};
        vecs[7]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h234, exp_t: 2'd2, exp_inst: 10'h3FF};
        vecs[8]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h345, exp_t: 2'd3, exp_inst: 10'h3FF};
        vecs[9]  = '{clr: 1'b0, irin: 1'b0, bus: 10'h056, exp_t: 2'd0, exp_inst: 10'h3FF};
        vecs[10] = '{clr: 1'b1, irin: 1'b0, bus: 10'h2AA, exp_t: 2'd0, exp_inst: 10'h3FF};
        vecs[11] = '{clr: 1'b0, irin: 1'b1, bus: 10'h000, exp_t: 2'd1, exp_inst: 10'h000};

        rst    = 1'b1;
        exec_n = 1'b1;
        bus    = '0;
        IRin   = 1'b0;
        Clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset T", {30'd0, T}, 32'd0);
        check("reset INST", {22'd0, INST}, 32'd0);
        check("reset step", {31'd0, step}, 32'd0);
        rst = 1'b0;
        idle(4, n);
        check("idle no_step", n, 0);

        // Bounce: toggles every 2 cycles for 16 cycles must never qualify.
        IRin = 1'b1;
        Clr  = 1'b1;
        bus  = 10'h3C3;
        n    = 0;
        for (int i = 0; i < 8; i++) begin
            int s;
            exec_n = ~exec_n;
            idle(2, s);
            n += s;
        end
        exec_n = 1'b1;
        begin
            int s;
            idle(12, s);
            n += s;
        end
        check("bounce no_step", n, 0);
        check("bounce T", {30'd0, T}, 32'd0);
        check("bounce INST", {22'd0, INST}, 32'd0);
        IRin = 1'b0;
        Clr  = 1'b0;

        // Clean press, button held ~20 cycles: one step, T 0->1.
        exp_q.push_back({2'd1, 10'h000});
        press("clean", 1'b0, 1'b0, 10'h155, 2'd0, 10'h000, 11);

        // Table-driven presses: capture, hold, wrap, clear priority.
        for (int i = 0; i < 12; i++) begin
            logic [1:0] ht;
            logic [9:0] hi;
            ht = (i == 0) ? 2'd1 : vecs[i-1].exp_t;
            hi = (i == 0) ? 10'h000 : vecs[i-1].exp_inst;
            exp_q.push_back({vecs[i].exp_t, vecs[i].exp_inst});
            press($sformatf("vec%0d", i), vecs[i].clr, vecs[i].irin, vecs[i].bus, ht, hi, 4);
        end
        check("queue drained", exp_q.size(), 0);

        // Reset two cycles into a held press: progress discarded, one step
        // exactly 7 cycles after rst falls.
        exec_n = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst T", {30'd0, T}, 32'd0);
        check("midrst INST", {22'd0, INST}, 32'd0);
        check("midrst step", {31'd0, step}, 32'd0);
        rst = 1'b0;
        wait_step(15, cyc, seen);
        check("midrst step_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("midrst latency", cyc, 7);
            @(negedge clk);
            check("midrst T", {30'd0, T}, 32'd1);
            check("midrst INST", {22'd0, INST}, 32'd0);
        end
        idle(10, n);
        check("midrst single_step", n, 0);
        exec_n = 1'b1;
        idle(12, n);
        check("midrst release_no_step", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timestep_sequencer.md
TIMESTEP_SEQUENCER -- requirements
Module: timestep_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 250000, consecutive stable synchronized cycles required to accept a new button level (5 ms at 50 MHz).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 exec_n  input  1  raw active-low Execute push-button, asynchronous to clk, bouncy.
REQ-005 bus  input  10  shared data bus value, captured into the instruction register.
REQ-006 IRin  input  1  controller enable to capture bus into the instruction register.
REQ-007 Clr  input  1  controller clear for the timestep counter.
REQ-008 INST  output  10  registered current instruction, fed to the controller.
REQ-009 T  output  2  registered current timestep, fed to the controller.
REQ-010 step  output  1  one-cycle pulse per accepted button press; qualifies all register-file, A, G and IR writes.

Function
REQ-011 The block SHALL pass exec_n through a two-flop synchronizer, then invert it to active-high level btn_s.
REQ-012 The debouncer SHALL hold a debounced level btn_d and a counter. When btn_s equals btn_d, the counter clears. When it differs, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_d takes btn_s and the counter clears.
REQ-013 step SHALL assert for exactly one cycle, in the cycle after btn_d rises 0->1. A 1->0 transition of btn_d SHALL produce no pulse.
REQ-014 Latency SHALL be fixed: a clean press reaching exec_n gives step high 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later, ±1 cycle for the asynchronous sampling point.
REQ-015 Bounces shorter than DEBOUNCE_CYCLES SHALL restart the counter and produce no step.
REQ-016 Holding the button SHALL produce exactly one step. A new step requires a debounced release followed by a debounced press.
REQ-017 T SHALL change only on a clock edge where step=1:
- if Clr=1, T becomes 0;
- otherwise T becomes T+1 modulo 4 (3 wraps to 0).
REQ-018 Clr SHALL have priority over increment when both apply. Clr with step=0 SHALL have no effect.
REQ-019 INST SHALL load bus on a clock edge where step=1 and IRin=1; otherwise INST SHALL hold. IRin with step=0 SHALL have no effect.
REQ-020 When step=1 and both IRin=1 and Clr=1, the capture of INST and the clear of T SHALL occur on the same edge.
REQ-021 T and INST SHALL be driven directly from flops, with no combinational path from bus, IRin or Clr to any output.

Reset
REQ-022 While rst=1, the following SHALL be 0: T, INST, step, btn_d, the debounce counter and both synchronizer flops. The synchronizer flops reset to the "not pressed" value.
REQ-023 Reset asserted mid-press or mid-debounce SHALL discard all progress. A button held through rst deassertion SHALL yield exactly one step, DEBOUNCE_CYCLES+3 cycles after release of rst.

Structure
REQ-024 A shared package SHALL define:
- the timestep typedef (2-bit, values T0..T3);
- the 10-bit word width constant;
- the DEBOUNCE_CYCLES default constant.
The controller SHALL use the same package.
REQ-025 Synchronizer, debouncer and edge detection SHALL form one sub-module, named button_debouncer, with ports clk, rst, btn_n, pulse. The counter width SHALL be $clog2(DEBOUNCE_CYCLES).
REQ-026 The top level SHALL contain only the timestep counter and the instruction register, plus one button_debouncer instance.

Verification (DEBOUNCE_CYCLES overridden to 4)
REQ-027 Clean press, exec_n low for 20 cycles after reset:
- exactly one step pulse, 7±1 cycles after the falling edge;
- T goes 0->1.
REQ-028 Bounce, exec_n toggled every 2 cycles for 16 cycles, then released: no step; T and INST unchanged at 0.
REQ-029 Capture, bus=10'b10_01_000101 with IRin=1 on the step cycle:
- INST=0x245 on the next cycle;
- with IRin=0 on the next three presses, INST holds 0x245.
REQ-030 Wrap, four presses with Clr=0: T sequence 1,2,3,0.
REQ-031 Clear priority, T=2 with Clr=1 and IRin=1 during step, bus=0x3FF: T=0 and INST=0x3FF on the same edge.
REQ-032 Reset mid-debounce, rst pulsed for 1 cycle two cycles into a held press:
- all outputs 0 during rst;
- exactly one step, 7 cycles after rst falls;
- T=1.
